nand_seq_core: RTL and testbench

Parametrised successor to the team's 1-bit NAND/branch processor. It executes one instruction per clock from an internal instruction memory. Register-file sizes, address width and memory depth are configurable, and it adds:
- a handshaked serial program loader,
- an explicit IDLE/RUN/HALT run-control FSM,
- program-length masking, so the memory needs no reset clear,
- an encoded halt instruction,
- LSB-first field encoding throughout, with no bit-reversed decoding.

It sits between board I/O pins (`in_reg`/`out_reg`) and a host/loader that streams programs one bit per cycle.

---
 rtl/nand_seq_core.sv | 163 ++++++++++++++++
 tb/tb_nand_seq_core.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/nand_seq_core.sv
// nand_seq_core: 1-bit NAND/branch processor with serial program loader and run-control FSM
// Ports:
//   clk_i, reset_i        clock (rising edge), synchronous active-high reset
//   in_reg_i              board input registers (read-only, addresses 1..NUM_IN)
//   load_valid_i/bit_i    serial program stream, LSB of each word first
//   load_ready_o          loader accepts bits (IDLE or HALT)
//   load_clear_i          discard loaded program
//   start_i, stop_i       run control pulses
//   out_reg_o             output registers
//   pc_o, prog_len_o      program counter, number of complete words loaded
//   running_o, halted_o   FSM status
module nand_seq_core #(
    parameter int NUM_IN     = 2,
    parameter int NUM_OUT    = 7,
    parameter int NUM_INT    = 6,
    parameter int ADDR_W     = 4,
    parameter int IMEM_DEPTH = 1024,
    parameter int PC_W       = 10
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic [NUM_IN-1:0]  in_reg_i,
    input  logic               load_valid_i,
    input  logic               load_bit_i,
    output logic               load_ready_o,
    input  logic               load_clear_i,
    input  logic               start_i,
    input  logic               stop_i,
    output logic [NUM_OUT-1:0] out_reg_o,
    output logic [PC_W-1:0]    pc_o,
    output logic [PC_W:0]      prog_len_o,
    output logic               running_o,
    output logic               halted_o
);
    localparam int INST_W = 1 + 3 * ADDR_W;
    localparam int OFF_W  = 2 * ADDR_W - 1;
    localparam int NREG   = 1 + NUM_IN + NUM_OUT + NUM_INT;
    localparam int BC_W   = $clog2(INST_W);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_e;

    state_e             state_q, state_d;
    logic [PC_W-1:0]    pc_q, pc_d, load_addr_q, load_addr_d;
    logic [PC_W:0]      prog_len_q, prog_len_d;
    logic [BC_W-1:0]    bit_cnt_q, bit_cnt_d;
    logic [INST_W-1:0]  word_q, word_d;
    logic [NUM_OUT-1:0] out_q, out_d;
    logic [NUM_INT-1:0] int_q, int_d;
    logic [INST_W-1:0]  imem [IMEM_DEPTH];
    logic [INST_W-1:0]  inst;
    logic [2**ADDR_W-1:0] rf;
    logic [ADDR_W-1:0]  ra, rb, rd;
    logic [OFF_W-1:0]   off;
    logic               ctrl, dir, taken, halt, nand_v, we, load_en, enter_run, word_done;

    // Words beyond the loaded length read as zero, which decodes as halt.
    assign inst = ({1'b0, pc_q} < prog_len_q) ? imem[pc_q] : '0;
    assign ctrl = inst[0];
    assign ra   = inst[ADDR_W:1];
    assign rb   = inst[2*ADDR_W:ADDR_W+1];
    assign rd   = inst[3*ADDR_W:2*ADDR_W+1];
    assign dir  = inst[ADDR_W+1];
    assign off  = inst[INST_W-1:ADDR_W+2];

    // Flat register map; unmapped addresses stay zero.
    always_comb begin
        rf = '0;
        rf[NREG-1:0] = {int_q, out_q, in_reg_i, 1'b1};
    end

    assign taken  = rf[ra];
    assign nand_v = ~(rf[ra] & rf[rb]);
    assign halt   = !ctrl && taken && (off == '0);

    assign enter_run = !stop_i && start_i && (state_q != RUN);
    assign load_en   = !stop_i && !start_i && (state_q != RUN);

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        we      = 1'b0;
        if (stop_i) begin
            state_d = IDLE;
            pc_d    = (state_q == RUN) ? '0 : pc_q;
        end else if (enter_run) begin
            state_d = RUN;
            pc_d    = '0;
        end else if (state_q == RUN) begin
            state_d = halt ? HALT : RUN;
            we      = ctrl;
            pc_d    = halt ? pc_q :
                      (ctrl || !taken) ? pc_q + PC_W'(1) :
                      dir ? pc_q - PC_W'(off) : pc_q + PC_W'(off);
        end
    end

    always_comb begin
        out_d = out_q;
        int_d = int_q;
        for (int i = 0; i < NUM_OUT; i++)
            out_d[i] = (we && rd == ADDR_W'(1 + NUM_IN + i)) ? nand_v : out_q[i];
        for (int i = 0; i < NUM_INT; i++)
            int_d[i] = (we && rd == ADDR_W'(1 + NUM_IN + NUM_OUT + i)) ? nand_v : int_q[i];
    end

    // Words shift in from the top so the first bit received ends up at bit 0.
    always_comb begin
        word_d      = word_q;
        bit_cnt_d   = bit_cnt_q;
        load_addr_d = load_addr_q;
        prog_len_d  = prog_len_q;
        word_done   = 1'b0;
        if (enter_run) begin
            bit_cnt_d = '0;
        end else if (load_en && load_clear_i) begin
            bit_cnt_d   = '0;
            load_addr_d = '0;
            prog_len_d  = '0;
        end else if (load_en && load_valid_i) begin
            word_d    = {load_bit_i, word_q[INST_W-1:1]};
            word_done = (bit_cnt_q == BC_W'(INST_W - 1));
            bit_cnt_d = word_done ? '0 : bit_cnt_q + BC_W'(1);
            if (word_done) begin
                load_addr_d = (load_addr_q == PC_W'(IMEM_DEPTH - 1)) ? '0 : load_addr_q + PC_W'(1);
                prog_len_d  = (prog_len_q == (PC_W+1)'(IMEM_DEPTH)) ? prog_len_q : prog_len_q + (PC_W+1)'(1);
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= IDLE;
            pc_q        <= '0;
            load_addr_q <= '0;
            prog_len_q  <= '0;
            bit_cnt_q   <= '0;
            word_q      <= '0;
            out_q       <= '0;
            int_q       <= '0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            load_addr_q <= load_addr_d;
            prog_len_q  <= prog_len_d;
            bit_cnt_q   <= bit_cnt_d;
            word_q      <= word_d;
            out_q       <= out_d;
            int_q       <= int_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i && word_done)
            imem[load_addr_q] <= word_d;
    end

    assign load_ready_o = (state_q != RUN);
    assign running_o    = (state_q == RUN);
    assign halted_o     = (state_q == HALT);
    assign out_reg_o    = out_q;
    assign pc_o         = pc_q;
    assign prog_len_o   = prog_len_q;
endmodule

// File: tb/tb_nand_seq_core.sv
// tb_nand_seq_core: directed self-checking bench for nand_seq_core
module tb_nand_seq_core;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [1:0] in_reg = '0;
    logic       load_valid = 1'b0;
    logic       load_bit = 1'b0;
    logic       load_ready;
    logic       load_clear = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [6:0] out_reg;
    logic [9:0] pc;
    logic [10:0] prog_len;
    logic       running;
    logic       halted;
    int total = 0;
    int bad = 0;

    nand_seq_core dut (
        .clk_i(clk), .reset_i(reset), .in_reg_i(in_reg),
        .load_valid_i(load_valid), .load_bit_i(load_bit), .load_ready_o(load_ready),
        .load_clear_i(load_clear), .start_i(start), .stop_i(stop),
        .out_reg_o(out_reg), .pc_o(pc), .prog_len_o(prog_len),
        .running_o(running), .halted_o(halted)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic load_word(input logic [12:0] w);
        for (int i = 0; i < 13; i++) begin
            load_valid = 1'b1;
            load_bit   = w[i];
            step();
        end
        load_valid = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    initial begin
        logic [12:0] w;
        // 1: reset state, empty program halts immediately
        do_reset();
        check("rst_ready", 32'(load_ready), 32'd1);
        check("rst_running", 32'(running), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_pc", 32'(pc), 32'd0);
        check("rst_plen", 32'(prog_len), 32'd0);
        check("rst_out", 32'(out_reg), 32'd0);
        pulse_start();
        check("t1_running", 32'(running), 32'd1);
        check("t1_ready", 32'(load_ready), 32'd0);
        step();
        check("t1_halted", 32'(halted), 32'd1);
        check("t1_pc", 32'(pc), 32'd0);
        check("t1_out", 32'(out_reg), 32'd0);

        // 2: NAND writes out_reg[0], then halt
        do_reset();
        load_word(13'h603);
        load_word(13'h000);
        check("t2_plen", 32'(prog_len), 32'd2);
        in_reg = 2'b00;
        pulse_start();
        step();
        check("t2_out_e1", 32'(out_reg), 32'h01);
        check("t2_run_e1", 32'(running), 32'd1);
        check("t2_pc_e1", 32'(pc), 32'd1);
        step();
        check("t2_halted", 32'(halted), 32'd1);
        check("t2_pc", 32'(pc), 32'd1);
        check("t2_out", 32'(out_reg), 32'h01);

        // 3: conditional branch skips the NAND, then restart from HALT
        do_reset();
        load_word(13'h084);
        load_word(13'h803);
        load_word(13'h000);
        check("t3_plen", 32'(prog_len), 32'd3);
        in_reg = 2'b10;
        pulse_start();
        step();
        check("t3a_pc_e1", 32'(pc), 32'd2);
        check("t3a_run_e1", 32'(running), 32'd1);
        step();
        check("t3a_halted", 32'(halted), 32'd1);
        check("t3a_pc", 32'(pc), 32'd2);
        check("t3a_out", 32'(out_reg), 32'h00);
        in_reg = 2'b00;
        pulse_start();
        check("t3b_pc0", 32'(pc), 32'd0);
        check("t3b_running", 32'(running), 32'd1);
        step();
        check("t3b_pc_e1", 32'(pc), 32'd1);
        step();
        check("t3b_out_e2", 32'(out_reg), 32'h02);
        step();
        check("t3b_halted", 32'(halted), 32'd1);
        check("t3b_pc", 32'(pc), 32'd2);

        // 4: backward branch wraps pc past the program end
        do_reset();
        load_word(13'h060);
        check("t4_plen", 32'(prog_len), 32'd1);
        pulse_start();
        step();
        check("t4_pc_wrap", 32'(pc), 32'd1023);
        check("t4_run", 32'(running), 32'd1);
        step();
        check("t4_halted", 32'(halted), 32'd1);
        check("t4_pc", 32'(pc), 32'd1023);

        // 5: start during a partial word discards it; load_clear and bit counting in HALT
        do_reset();
        load_word(13'h603);
        w = 13'h1fff;
        for (int i = 0; i < 6; i++) begin
            load_valid = 1'b1;
            load_bit   = w[i];
            step();
        end
        load_valid = 1'b1;
        load_bit   = 1'b1;
        start      = 1'b1;
        step();
        start      = 1'b0;
        load_valid = 1'b0;
        check("t5_running", 32'(running), 32'd1);
        check("t5_plen_run", 32'(prog_len), 32'd1);
        step();
        step();
        check("t5_halted", 32'(halted), 32'd1);
        check("t5_plen_halt", 32'(prog_len), 32'd1);
        check("t5_out", 32'(out_reg), 32'h01);
        load_clear = 1'b1;
        step();
        load_clear = 1'b0;
        check("t5_plen_clr", 32'(prog_len), 32'd0);
        for (int i = 0; i < 12; i++) begin
            load_valid = 1'b1;
            load_bit   = 1'b0;
            step();
        end
        check("t5_plen_12b", 32'(prog_len), 32'd0);
        step();
        load_valid = 1'b0;
        check("t5_plen_13b", 32'(prog_len), 32'd1);

        // 6: endless two-word loop, load_valid ignored in RUN, stop returns to IDLE
        do_reset();
        in_reg = 2'b00;
        load_word(13'h803);
        load_word(13'h060);
        pulse_start();
        load_valid = 1'b1;
        load_bit   = 1'b1;
        for (int i = 0; i < 15; i++) step();
        load_valid = 1'b0;
        check("t6_running", 32'(running), 32'd1);
        check("t6_pc_loop", 32'(pc), 32'd1);
        check("t6_out_loop", 32'(out_reg), 32'h02);
        check("t6_plen_run", 32'(prog_len), 32'd2);
        stop = 1'b1;
        step();
        stop = 1'b0;
        check("t6_stop_run", 32'(running), 32'd0);
        check("t6_stop_halt", 32'(halted), 32'd0);
        check("t6_stop_pc", 32'(pc), 32'd0);
        check("t6_stop_out", 32'(out_reg), 32'h02);
        check("t6_stop_ready", 32'(load_ready), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
